// File: rtl/wb_port_arbiter_pkg.sv
// Shared types for the GPR write-port arbiter: request/entry structs and register-index helpers.
package wb_port_arbiter_pkg;
    localparam int REG_W    = 5;
    localparam int XLEN     = 64;
    localparam int NUM_REGS = 32;

    typedef struct packed {
        logic             rd_en;
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  rd_value;
    } wb_req_t;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic [XLEN-1:0]  value;
    } lu_entry_t;

    function automatic logic [NUM_REGS-1:0] rd_onehot(input logic [REG_W-1:0] rd);
        return NUM_REGS'(1) << rd;
    endfunction
endpackage

// File: rtl/wb_lu_fifo.sv
// Circular buffer for long-latency results; exports per-entry destination and valid bits
// so the parent can build the pending-destination mask.
module wb_lu_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        push,
    input  lu_entry_t                   push_entry,
    input  logic                        pop,
    output lu_entry_t                   head,
    output logic                        full,
    output logic                        empty,
    output logic [DEPTH-1:0]            entry_vld,
    output logic [DEPTH-1:0][REG_W-1:0] entry_rd
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    lu_entry_t [DEPTH-1:0] mem;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Caller only pushes when not full and pops when not empty; pointers wrap naturally.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            entry_vld <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;
            if (pop)  entry_vld[rd_ptr] <= 1'b0;
            if (push) entry_vld[wr_ptr] <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (push) mem[wr_ptr] <= push_entry;
    end

    always_comb begin
        entry_rd = '0;
        for (int i = 0; i < DEPTH; i++) entry_rd[i] = mem[i].rd;
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the GPR write port between pipeline writeback (always wins) and buffered
// long-latency results, which drain into idle slots; requests a bubble on starvation.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                pipe_rd_en,
    input  logic [REG_W-1:0]    pipe_rd,
    input  logic [XLEN-1:0]     pipe_rd_value,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [REG_W-1:0]    lu_rd,
    input  logic [XLEN-1:0]     lu_rd_value,
    output logic                commit_rd_en,
    output logic [REG_W-1:0]    commit_rd,
    output logic [XLEN-1:0]     commit_rd_value,
    output logic                commit_src,
    output logic [NUM_REGS-1:0] pending_mask,
    output logic                stall_req
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    lu_entry_t                   head;
    logic                        full, empty;
    logic [DEPTH-1:0]            entry_vld;
    logic [DEPTH-1:0][REG_W-1:0] entry_rd;
    logic                        eff_pipe, push, pop, grant_src;
    wb_req_t                     grant, commit_q;
    logic [SC_W-1:0]             starve_cnt;

    assign eff_pipe = pipe_rd_en && (pipe_rd != '0);
    assign pop      = !eff_pipe && !empty;
    assign lu_ready = !full;
    // Writes to x0 are acknowledged but never buffered.
    assign push     = lu_valid && lu_ready && (lu_rd != '0);

    wb_lu_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push       (push),
        .push_entry ('{rd: lu_rd, value: lu_rd_value}),
        .pop        (pop),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .entry_vld  (entry_vld),
        .entry_rd   (entry_rd)
    );

    always_comb begin
        grant     = '0;
        grant_src = 1'b0;
        if (eff_pipe) begin
            grant.rd_en    = 1'b1;
            grant.rd       = pipe_rd;
            grant.rd_value = pipe_rd_value;
        end else if (pop) begin
            grant.rd_en    = 1'b1;
            grant.rd       = head.rd;
            grant.rd_value = head.value;
            grant_src      = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            commit_q   <= '0;
            commit_src <= 1'b0;
            starve_cnt <= '0;
        end else begin
            commit_q   <= grant;
            commit_src <= grant_src;
            if (empty || pop)                          starve_cnt <= '0;
            else if (starve_cnt != SC_W'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
        end
    end

    assign commit_rd_en    = commit_q.rd_en;
    assign commit_rd       = commit_q.rd;
    assign commit_rd_value = commit_q.rd_value;
    assign stall_req       = (starve_cnt == SC_W'(STARVE_LIMIT));

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (entry_vld[i]) pending_mask = pending_mask | rd_onehot(entry_rd[i]);
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench: stimulus drives on negedge and pushes the expected commit of each slot;
// a monitor after each posedge pops and compares commit, lu_ready, pending_mask and stall_req.
module tb_wb_port_arbiter;
    localparam int DEPTH = 2;
    localparam int LIMIT = 4;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        pipe_rd_en;
    logic [4:0]  pipe_rd;
    logic [63:0] pipe_rd_value;
    logic        lu_valid, lu_ready;
    logic [4:0]  lu_rd;
    logic [63:0] lu_rd_value;
    logic        commit_rd_en, commit_src, stall_req;
    logic [4:0]  commit_rd;
    logic [63:0] commit_rd_value;
    logic [31:0] pending_mask;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clock(clock), .reset_n(reset_n),
        .pipe_rd_en(pipe_rd_en), .pipe_rd(pipe_rd), .pipe_rd_value(pipe_rd_value),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_rd_value(lu_rd_value),
        .commit_rd_en(commit_rd_en), .commit_rd(commit_rd), .commit_rd_value(commit_rd_value),
        .commit_src(commit_src), .pending_mask(pending_mask), .stall_req(stall_req)
    );

    always #5 clock = ~clock;

    typedef struct { bit en; bit [4:0] rd; bit [63:0] val; bit src; } exp_t;
    typedef struct { bit [4:0] rd; bit [63:0] val; } ent_t;

    exp_t exp_q[$];
    ent_t mq[$];      // reference: LU results waiting, oldest first
    int   m_starve;   // reference: consecutive buffered-but-undrained cycles
    bit   in_reset;
    int   tests, fails;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    function automatic bit [31:0] model_pending();
        bit [31:0] m = '0;
        foreach (mq[i]) m[mq[i].rd] = 1'b1;
        return m;
    endfunction

    // One slot: drive inputs on negedge, predict what the register file sees next cycle.
    task automatic step(input bit pe, input bit [4:0] prd, input bit [63:0] pv,
                        input bit lv, input bit [4:0] lrd, input bit [63:0] lval,
                        output bit accepted);
        bit   ready, was_empty, popped;
        ent_t e;
        @(negedge clock);
        pipe_rd_en = pe; pipe_rd = prd; pipe_rd_value = pv;
        lu_valid = lv; lu_rd = lrd; lu_rd_value = lval;
        ready     = mq.size() < DEPTH;
        was_empty = mq.size() == 0;
        popped    = 1'b0;
        if (pe && prd != 0) exp_q.push_back('{1'b1, prd, pv, 1'b0});
        else if (!was_empty) begin
            e = mq.pop_front();
            exp_q.push_back('{1'b1, e.rd, e.val, 1'b1});
            popped = 1'b1;
        end else exp_q.push_back('{1'b0, 5'd0, 64'd0, 1'b0});
        accepted = lv && ready;
        if (accepted && lrd != 0) mq.push_back('{lrd, lval});
        if (was_empty || popped) m_starve = 0;
        else if (m_starve < LIMIT) m_starve++;
    endtask

    task automatic idle(input int n);
        bit a;
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, a);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rd_en"}, commit_rd_en, 0);
        chk({tag, "_rd"}, commit_rd, 0);
        chk({tag, "_value"}, commit_rd_value, 0);
        chk({tag, "_src"}, commit_src, 0);
        chk({tag, "_lu_ready"}, lu_ready, 1);
        chk({tag, "_pending"}, pending_mask, 0);
        chk({tag, "_stall"}, stall_req, 0);
    endtask

    // Monitor: one expectation per slot, observed just after the edge that loads it.
    always begin
        exp_t e;
        @(posedge clock);
        #1;
        if (!in_reset) begin
            if (exp_q.size() == 0) begin
                chk("sb_underflow", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("commit_rd_en", commit_rd_en, e.en);
                chk("commit_rd", commit_rd, e.rd);
                chk("commit_value", commit_rd_value, e.val);
                chk("commit_src", commit_src, e.src);
            end
            chk("lu_ready", lu_ready, mq.size() < DEPTH);
            chk("pending_mask", pending_mask, model_pending());
            chk("stall_req", stall_req, m_starve == LIMIT);
        end
    end

    always @(posedge clock)
        if (reset_n && !in_reset)
            assert (!(pipe_rd_en && pipe_rd != 0 && pending_mask[pipe_rd]))
            else $error("protocol: pipeline write to pending rd %0d", pipe_rd);

    initial begin
        bit        a;
        int        sent, prob;
        bit [4:0]  prd, lrd;
        bit [31:0] pend;
        bit        pe, lv;

        in_reset = 1; reset_n = 0;
        pipe_rd_en = 0; pipe_rd = 0; pipe_rd_value = 0;
        lu_valid = 0; lu_rd = 0; lu_rd_value = 0;
        m_starve = 0;
        #8 check_reset_outputs("por");
        @(posedge clock); #2 reset_n = 1; in_reset = 0;

        // Idle drain: commit two edges after the push, pending bit for one cycle.
        step(0, 0, 0, 1, 5, 64'hDEAD, a);
        idle(3);

        // Pipeline priority over a buffered rd=7.
        step(1, 3, 64'h31, 1, 7, 64'h77, a);
        step(1, 3, 64'h32, 0, 0, 0, a);
        step(1, 3, 64'h33, 0, 0, 0, a);
        idle(3);

        // Backpressure: third result held until the first pop frees a slot.
        sent = 0;
        for (int c = 0; c < 12; c++) begin
            step(c < 6, 1, 64'h100 + c, sent < 3, 5'(10 + sent), 64'hA0 + sent, a);
            if (a && sent < 3) sent++;
        end
        idle(3);

        // Starvation then bubble.
        step(1, 2, 64'h200, 1, 9, 64'h99, a);
        for (int c = 0; c < 6; c++) step(1, 2, 64'h201 + c, 0, 0, 0, a);
        idle(3);

        // x0: discarded push, and pipe rd=0 does not block a drain.
        step(0, 0, 0, 1, 0, 64'hBAD, a);
        step(1, 6, 64'h600, 1, 4, 64'h44, a);
        step(1, 0, 64'h999, 0, 0, 0, a);
        idle(2);

        // Randomised traffic with varying pipeline pressure.
        for (int c = 0; c < 1500; c++) begin
            prob = (c / 250) % 2 ? 90 : 40;
            pe = $urandom_range(0, 99) < prob;
            if (m_starve == LIMIT && $urandom_range(0, 1)) pe = 0;
            pend = model_pending();
            do prd = 5'($urandom_range(0, 31)); while (prd != 0 && pend[prd]);
            lv  = $urandom_range(0, 1);
            lrd = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            step(pe, prd, {$urandom, $urandom}, lv, lrd, {$urandom, $urandom}, a);
        end
        idle(4);

        // Reset mid-traffic with two results buffered.
        step(1, 1, 64'h11, 1, 20, 64'h20, a);
        step(1, 1, 64'h12, 1, 21, 64'h21, a);
        @(negedge clock);
        #2 in_reset = 1; reset_n = 0;
        pipe_rd_en = 0; lu_valid = 0; pipe_rd = 0; lu_rd = 0;
        #1 check_reset_outputs("async_rst");
        exp_q.delete(); mq.delete(); m_starve = 0;
        @(posedge clock); @(posedge clock); #2 reset_n = 1; in_reset = 0;
        idle(5);

        @(posedge clock); #2;
        chk("sb_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
